stopwatch_ctrl: RTL and testbench

Sequencing controller for the two-digit seconds counter on the 50 MHz board clock. It turns single-cycle start/stop, lap and clear pulses into a run/pause/idle state machine and gates a clock-enable tick divider. It owns a BCD 00–99 seconds count and presents a live or lap-frozen digit pair to the existing seven-segment decode stage.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/stopwatch_if.sv | 26 ++
 rtl/stopwatch_tick_divider.sv | 30 +++
 rtl/stopwatch_ctrl.sv | 112 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: state encoding,
// BCD digit sizing and the tick divider width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int                 DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Command pulses in, registered display/status outputs back.
// master drives the pulses; slave is the stopwatch controller.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic               start_stop;
    logic               lap;
    logic               clear;
    logic               tick_en;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    logic               running;
    logic               lap_active;
    logic               wrap;

    modport master (
        output start_stop, lap, clear,
        input  tick_en, tens, ones, running, lap_active, wrap
    );

    modport slave (
        input  start_stop, lap, clear,
        output tick_en, tens, ones, running, lap_active, wrap
    );

endinterface

// File: rtl/stopwatch_tick_divider.sv
// Modulo-DIV clock-enable divider with hold and synchronous zero.
// Latency: tick_en is high in the cycle the count sits at DIV-1; no backpressure.
module tick_divider
    import stopwatch_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic zero,
    output logic tick_en
);

    localparam int           W    = div_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick_en = !hold && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || zero) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= tick_en ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle stopwatch with BCD 00-99 seconds and lap freeze (STOPWATCH_LAP_EN).
// Latency: all outputs registered, commands take effect next cycle; no backpressure.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    stopwatch_if.slave  bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    state_t             state, state_nxt;
    logic               clear_evt;
    logic               tick;
    logic               wrap_q;
    logic [DIGIT_W-1:0] live_tens, live_ones;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // start_stop wins over clear, so clear only acts on a quiet PAUSE cycle
    always_comb begin
        state_nxt = state;
        clear_evt = 1'b0;
        case (state)
            IDLE:  if (bus.start_stop) state_nxt = RUN;
            RUN:   if (bus.start_stop) state_nxt = PAUSE;
            PAUSE: begin
                if (bus.start_stop) begin
                    state_nxt = RUN;
                end else if (bus.clear) begin
                    state_nxt = IDLE;
                    clear_evt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    tick_divider #(.DIV(DIV)) u_div (
        .clk     (clk),
        .reset   (reset),
        .hold    (state != RUN),
        .zero    (clear_evt),
        .tick_en (tick)
    );

    always_ff @(posedge clk) begin
        if (reset || clear_evt) begin
            live_tens <= '0;
            live_ones <= '0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= tick && (live_tens == DIGIT_MAX) && (live_ones == DIGIT_MAX);
            if (tick) begin
                if (live_ones == DIGIT_MAX) begin
                    live_ones <= '0;
                    live_tens <= (live_tens == DIGIT_MAX) ? '0 : live_tens + 1'b1;
                end else begin
                    live_ones <= live_ones + 1'b1;
                end
            end
        end
    end

    assign bus.tick_en = tick;
    assign bus.running = (state == RUN);
    assign bus.wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic               lap_q;
    logic [DIGIT_W-1:0] frz_tens, frz_ones;

    // Freeze captures the count as it stands this cycle; a pending tick lands after
    always_ff @(posedge clk) begin
        if (reset || clear_evt) begin
            lap_q    <= 1'b0;
            frz_tens <= '0;
            frz_ones <= '0;
        end else if (bus.lap && !bus.start_stop) begin
            if (state == RUN) begin
                if (!lap_q) begin
                    frz_tens <= live_tens;
                    frz_ones <= live_ones;
                    lap_q    <= 1'b1;
                end else begin
                    lap_q    <= 1'b0;
                end
            end else if (state == PAUSE) begin
                lap_q <= 1'b0;
            end
        end
    end

    assign bus.lap_active = lap_q;
    assign bus.tens       = lap_q ? frz_tens : live_tens;
    assign bus.ones       = lap_q ? frz_ones : live_ones;
`else
    logic unused_lap;
    assign unused_lap     = bus.lap;
    assign bus.lap_active = 1'b0;
    assign bus.tens       = live_tens;
    assign bus.ones       = live_ones;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl at DIV=10: per-cycle comparison against an
// arithmetic seconds/phase model plus hand-computed directed expectations.
module tb_stopwatch_ctrl;

    localparam int DIV = 10;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stopwatch_if bus();

    stopwatch_ctrl #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Model: seconds as an integer 0..99, phase as the position within a second
    bit m_run, m_pause, m_lap, m_wrap;
    int m_secs, m_phase, m_frozen;

    initial begin
        m_run = 0; m_pause = 0; m_lap = 0; m_wrap = 0;
        m_secs = 0; m_phase = 0; m_frozen = 0;
    end

    always @(posedge clk) begin : model
        bit tk;
        int old;
        if (reset) begin
            m_run = 0; m_pause = 0; m_lap = 0; m_wrap = 0;
            m_secs = 0; m_phase = 0; m_frozen = 0;
        end else begin
            tk     = m_run && (m_phase == DIV - 1);
            old    = m_secs;
            m_wrap = tk && (old == 99);
            if (m_run) m_phase = tk ? 0 : m_phase + 1;
            if (tk)    m_secs  = (old + 1) % 100;
            if (bus.start_stop) begin
                m_pause = m_run;
                m_run   = !m_run;
            end else if (bus.clear && m_pause) begin
                m_pause = 0; m_secs = 0; m_phase = 0; m_lap = 0;
            end else if (bus.lap && LAP_EN) begin
                if (m_run) begin
                    if (!m_lap) begin
                        m_frozen = old;
                        m_lap    = 1;
                    end else begin
                        m_lap = 0;
                    end
                end else if (m_pause) begin
                    m_lap = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int d;
        logic [11:0] exp_v, act_v;
        if (cyc >= 1) begin
            d     = m_lap ? m_frozen : m_secs;
            exp_v = {m_run && (m_phase == DIV - 1), m_run, m_lap, m_wrap, 4'(d / 10), 4'(d % 10)};
            act_v = {bus.tick_en, bus.running, bus.lap_active, bus.wrap, bus.tens, bus.ones};
            check("model", {20'd0, act_v}, {20'd0, exp_v});
        end
    end

    task automatic pulse(input bit s, input bit l, input bit c);
        bus.start_stop = s;
        bus.lap        = l;
        bus.clear      = c;
        @(negedge clk);
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;
    endtask

    task automatic wait_tick(output int tc);
        tc = -1;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            if (bus.tick_en === 1'b1) begin
                tc = cyc;
                break;
            end
        end
        check("tick_seen", {31'd0, tc >= 0}, 32'd1);
    endtask

    task automatic wait_ticks(input int n);
        int tc;
        for (int i = 0; i < n; i++) wait_tick(tc);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int t0, tt, nt;
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.clear      = 1'b0;

        @(negedge clk);
        check("reset_outputs", {20'd0, bus.tick_en, bus.running, bus.lap_active, bus.wrap,
                                bus.tens, bus.ones}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // First start: running next cycle, first tick DIV cycles after the pulse
        t0 = cyc;
        pulse(1, 0, 0);
        check("run_latency", {31'd0, bus.running}, 32'd1);
        wait_tick(tt);
        check("first_tick_delay", tt - t0, DIV);
        @(negedge clk);
        check("first_ones", {28'd0, bus.ones}, 32'd1);

        // Roll through 99 into 00 with one wrap pulse
        wait_ticks(98);
        @(negedge clk);
        check("count_99", {24'd0, bus.tens, bus.ones}, 32'h99);
        wait_tick(tt);
        @(negedge clk);
        check("wrap_to_00", {23'd0, bus.wrap, bus.tens, bus.ones}, 32'h100);
        @(negedge clk);
        check("wrap_single", {31'd0, bus.wrap}, 32'd0);

        // Pause mid-second, resume continues the partial second
        wait_ticks(7);
        repeat (4) @(negedge clk);
        pulse(1, 0, 0);
        check("paused_at_07", {23'd0, bus.running, bus.tens, bus.ones}, 32'h007);
        repeat (50) @(negedge clk);
        t0 = cyc;
        pulse(1, 0, 0);
        wait_tick(tt);
        check("resume_tick_delay", tt - t0, 6);
        @(negedge clk);
        check("resume_ones_08", {24'd0, bus.tens, bus.ones}, 32'h08);

        // Lap freeze at 12, live keeps counting, release shows 17
        wait_ticks(4);
        @(negedge clk);
        pulse(0, 1, 0);
`ifdef STOPWATCH_LAP_EN
        check("lap_frozen_12", {23'd0, bus.lap_active, bus.tens, bus.ones}, 32'h112);
`else
        check("lap_ignored_12", {23'd0, bus.lap_active, bus.tens, bus.ones}, 32'h012);
`endif
        wait_ticks(5);
        @(negedge clk);
`ifdef STOPWATCH_LAP_EN
        check("lap_held_12", {23'd0, bus.lap_active, bus.tens, bus.ones}, 32'h112);
`else
        check("live_17", {23'd0, bus.lap_active, bus.tens, bus.ones}, 32'h017);
`endif
        pulse(0, 1, 0);
        check("lap_release_17", {23'd0, bus.lap_active, bus.tens, bus.ones}, 32'h017);

        // Clear while running is ignored
        pulse(0, 0, 1);
        check("run_clear_ignored", {23'd0, bus.running, bus.tens, bus.ones}, 32'h117);

        // start_stop beats clear in PAUSE; then a plain clear returns to idle
        wait_ticks(16);
        @(negedge clk);
        pulse(1, 0, 0);
        check("pause_33", {23'd0, bus.running, bus.tens, bus.ones}, 32'h033);
        pulse(1, 0, 1);
        check("ss_beats_clear", {23'd0, bus.running, bus.tens, bus.ones}, 32'h133);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        check("cleared_idle", {22'd0, bus.lap_active, bus.running, bus.tens, bus.ones}, 32'h000);
        pulse(0, 0, 1);
        pulse(0, 1, 0);

        // Reset mid-run with a freeze active
        pulse(1, 0, 0);
        wait_ticks(45);
        @(negedge clk);
        pulse(0, 1, 0);
        check("pre_reset_45", {24'd0, bus.tens, bus.ones}, 32'h45);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_run_reset", {20'd0, bus.tick_en, bus.running, bus.lap_active, bus.wrap,
                                bus.tens, bus.ones}, 32'd0);
        nt = 0;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (bus.tick_en === 1'b1) nt++;
        end
        check("idle_no_tick", nt, 0);
        check("idle_not_running", {31'd0, bus.running}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
